branch_predictor_table: RTL and testbench

- Parametrised successor to the single-counter branch predictor.
- Holds a table of 2^INDEX_BITS saturating counters indexed by branch PC, plus misprediction statistics.
- Lookup happens in ID: the combinational prediction drives IF flush/redirect.
- Update happens in EX once the branch outcome (ALU zero) is known. The index used at lookup travels down the pipe with the branch and returns on update.

---
 rtl/branch_predictor_table.sv | 97 +++++++++
 tb/tb_branch_predictor_table.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_table.sv
// PC-indexed table of saturating branch counters with misprediction statistics.
// Optional gshare indexing is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor_table #(
  parameter int unsigned PC_W       = 32,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned HIST_BITS  = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [PC_W-1:0]       lookup_pc_i,
  output logic                  predict_o,
  output logic [INDEX_BITS-1:0] predict_idx_o,
  input  logic                  update_i,
  input  logic [INDEX_BITS-1:0] update_idx_i,
  input  logic                  result_i,
  input  logic                  update_pred_i,
  input  logic                  clear_stats_i,
  output logic [CNT_W-1:0]      branch_cnt_o,
  output logic [CNT_W-1:0]      mispredict_cnt_o
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;

  logic [CTR_BITS-1:0]   table_q [ENTRIES];
  logic [INDEX_BITS-1:0] pc_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [CTR_BITS-1:0]   upd_ctr;
  logic [CTR_BITS-1:0]   upd_ctr_next;
  logic                  unused_pc_bits;

  // Word-aligned PC bits select the entry; the rest of the PC is not part of the hash.
  assign pc_idx         = lookup_pc_i[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc_i[PC_W-1:INDEX_BITS+2], lookup_pc_i[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [HIST_BITS-1:0] ghr_q;

  // History shifts only on resolved branches; lookups see the pre-update value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ghr_q <= '0;
    end else if (update_i) begin
      ghr_q <= HIST_BITS'({ghr_q, result_i});
    end
  end

  assign lookup_idx = pc_idx ^ INDEX_BITS'(ghr_q);
`else
  assign lookup_idx = pc_idx;
`endif

  assign predict_idx_o = lookup_idx;
  assign predict_o     = table_q[lookup_idx][CTR_BITS-1];

  // Saturating increment/decrement of the entry being resolved.
  always_comb begin
    upd_ctr      = table_q[update_idx_i];
    upd_ctr_next = upd_ctr;
    if (result_i) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i] <= CTR_INIT;
      end
    end else if (update_i) begin
      table_q[update_idx_i] <= upd_ctr_next;
    end
  end

  // Statistics saturate at all-ones; clear wins over a same-cycle update.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else if (clear_stats_i) begin
      branch_cnt_o     <= '0;
      mispredict_cnt_o <= '0;
    end else if (update_i) begin
      if (branch_cnt_o != CNT_MAX) branch_cnt_o <= branch_cnt_o + CNT_W'(1);
      if ((update_pred_i != result_i) && (mispredict_cnt_o != CNT_MAX)) begin
        mispredict_cnt_o <= mispredict_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor_table.sv
// Directed, table-driven bench for branch_predictor_table (default parameters).
module tb_branch_predictor_table;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] lookup_pc_i;
  logic        predict_o;
  logic [3:0]  predict_idx_o;
  logic        update_i;
  logic [3:0]  update_idx_i;
  logic        result_i;
  logic        update_pred_i;
  logic        clear_stats_i;
  logic [15:0] branch_cnt_o;
  logic [15:0] mispredict_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor_table dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .lookup_pc_i(lookup_pc_i),
    .predict_o(predict_o),
    .predict_idx_o(predict_idx_o),
    .update_i(update_i),
    .update_idx_i(update_idx_i),
    .result_i(result_i),
    .update_pred_i(update_pred_i),
    .clear_stats_i(clear_stats_i),
    .branch_cnt_o(branch_cnt_o),
    .mispredict_cnt_o(mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc;
    logic        upd;
    logic [3:0]  uidx;
    logic        res;
    logic        upred;
    logic        clr;
    logic        exp_pred;
    logic [3:0]  exp_idx;
    logic [15:0] exp_b;
    logic [15:0] exp_m;
  } vec_t;

  task automatic check(input string name, input int vnum, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, vnum, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic upd, input logic [3:0] uidx,
                       input logic res, input logic upred, input logic clr);
    lookup_pc_i   = pc;
    update_i      = upd;
    update_idx_i  = uidx;
    result_i      = res;
    update_pred_i = upred;
    clear_stats_i = clr;
  endtask

  task automatic check_all(input int vnum, input logic ep, input logic [3:0] ei,
                           input logic [15:0] eb, input logic [15:0] em);
    check("predict_o", vnum, 32'(predict_o), 32'(ep));
    check("predict_idx_o", vnum, 32'(predict_idx_o), 32'(ei));
    check("branch_cnt_o", vnum, 32'(branch_cnt_o), 32'(eb));
    check("mispredict_cnt_o", vnum, 32'(mispredict_cnt_o), 32'(em));
  endtask

  vec_t vecs[24];

  initial begin
    // Each vector: inputs driven after negedge; expectations describe state before the next posedge.
    vecs[0]  = '{32'h0C, 1, 3, 1, 0, 0, 0, 3, 0, 0};
    vecs[1]  = '{32'h0C, 0, 0, 0, 0, 0, 1, 3, 1, 1};
    vecs[2]  = '{32'h10, 0, 0, 0, 0, 0, 0, 4, 1, 1};
    vecs[3]  = '{32'h14, 1, 5, 1, 1, 0, 0, 5, 1, 1};
    vecs[4]  = '{32'h14, 1, 5, 1, 1, 0, 1, 5, 2, 1};
    vecs[5]  = '{32'h14, 1, 5, 1, 1, 0, 1, 5, 3, 1};
    vecs[6]  = '{32'h14, 1, 5, 1, 1, 0, 1, 5, 4, 1};
    vecs[7]  = '{32'h14, 1, 5, 1, 1, 0, 1, 5, 5, 1};
    vecs[8]  = '{32'h14, 1, 5, 0, 1, 0, 1, 5, 6, 1};
    vecs[9]  = '{32'h14, 0, 0, 0, 0, 0, 1, 5, 7, 2};
    vecs[10] = '{32'h14, 1, 5, 0, 1, 0, 1, 5, 7, 2};
    vecs[11] = '{32'h14, 1, 5, 0, 0, 0, 0, 5, 8, 3};
    vecs[12] = '{32'h14, 1, 5, 0, 0, 0, 0, 5, 9, 3};
    vecs[13] = '{32'h14, 1, 5, 0, 0, 0, 0, 5, 10, 3};
    vecs[14] = '{32'h14, 1, 5, 1, 0, 0, 0, 5, 11, 3};
    vecs[15] = '{32'h14, 0, 0, 0, 0, 0, 0, 5, 12, 4};
    vecs[16] = '{32'h18, 1, 6, 0, 0, 0, 0, 6, 12, 4};
    vecs[17] = '{32'h18, 1, 6, 1, 0, 0, 0, 6, 13, 4};
    vecs[18] = '{32'h18, 1, 6, 1, 0, 0, 0, 6, 14, 5};
    vecs[19] = '{32'h18, 0, 0, 0, 0, 0, 1, 6, 15, 6};
    vecs[20] = '{32'h0C, 1, 3, 1, 1, 1, 1, 3, 15, 6};
    vecs[21] = '{32'h0C, 0, 0, 0, 0, 0, 1, 3, 0, 0};
    vecs[22] = '{32'h0C, 1, 3, 0, 1, 0, 1, 3, 0, 0};
    vecs[23] = '{32'h0C, 0, 0, 0, 0, 0, 1, 3, 1, 1};

    drive(32'h0, 0, 0, 0, 0, 0);
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_all(-1, 0, 0, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Every entry reads weakly-not-taken after reset.
    for (int i = 0; i < 16; i++) begin
      drive(32'(i * 4), 0, 0, 0, 0, 0);
      #1;
      check("reset_predict", i, 32'(predict_o), 32'd0);
      check("reset_idx", i, 32'(predict_idx_o), 32'(i));
      @(negedge clk_i);
    end
    check("reset_branch_cnt", 100, 32'(branch_cnt_o), 32'd0);
    check("reset_mispredict_cnt", 100, 32'(mispredict_cnt_o), 32'd0);

`ifndef BRANCH_PREDICTOR_GSHARE_EN
    for (int v = 0; v < 24; v++) begin
      drive(vecs[v].pc, vecs[v].upd, vecs[v].uidx, vecs[v].res, vecs[v].upred, vecs[v].clr);
      #1;
      check_all(v, vecs[v].exp_pred, vecs[v].exp_idx, vecs[v].exp_b, vecs[v].exp_m);
      @(negedge clk_i);
    end

    // Reset asserted while an update is pending: state clears at once and the update is lost.
    drive(32'h14, 1, 5, 1, 1, 0);
    #2;
    rst_i = 1'b1;
    #1;
    check_all(200, 0, 5, 0, 0);
    drive(32'h0C, 1, 3, 1, 1, 0);
    @(posedge clk_i);
    #1;
    check_all(201, 0, 3, 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(32'h0C, 0, 0, 0, 0, 0);
    #1;
    check_all(202, 0, 3, 0, 0);
    @(negedge clk_i);
    drive(32'h18, 0, 0, 0, 0, 0);
    #1;
    check_all(203, 0, 6, 0, 0);
    @(negedge clk_i);
`else
    // History T,T,NT,T gives ghr=4'b1101, so PC 0x10 hashes to 4^13=9.
    drive(32'h10, 1, 0, 1, 1, 0); @(negedge clk_i);
    drive(32'h10, 1, 0, 1, 1, 0); @(negedge clk_i);
    drive(32'h10, 1, 0, 0, 1, 0); @(negedge clk_i);
    drive(32'h10, 1, 0, 1, 1, 0);
    #1;
    check("gshare_pre_idx", 300, 32'(predict_idx_o), 32'd2);
    @(negedge clk_i);
    drive(32'h10, 0, 0, 0, 0, 0);
    #1;
    check("gshare_idx", 301, 32'(predict_idx_o), 32'd9);
    check("gshare_predict", 301, 32'(predict_o), 32'd0);
    check("gshare_branch_cnt", 301, 32'(branch_cnt_o), 32'd4);
    check("gshare_mispredict_cnt", 301, 32'(mispredict_cnt_o), 32'd1);
    @(negedge clk_i);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
